// File: rtl/lcd_capture.sv
// lcd_capture: packs 2bpp LCD pixels four per byte and streams each frame into a framebuffer through a small write FIFO
module lcd_capture #(
    parameter int H_PIXELS   = 160,
    parameter int V_LINES    = 144,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hs,
    input  logic              vs,
    input  logic              cpl,
    input  logic [1:0]        pixel,
    input  logic              valid,
    input  logic              clr_status,
    output logic [ADDR_W-1:0] fb_a,
    output logic [7:0]        fb_d,
    output logic              fb_wr,
    input  logic              fb_ready,
    output logic              frame_done,
    output logic              overflow,
    output logic              short_line
);
    localparam int XW = $clog2(H_PIXELS + 1);
    localparam int YW = $clog2(V_LINES + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [XW-1:0]     X_MAX  = XW'(H_PIXELS);
    localparam logic [YW-1:0]     Y_MAX  = YW'(V_LINES);
    localparam logic [CW-1:0]     C_MAX  = CW'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_PIXELS / 4);

    typedef enum logic [1:0] {SYNC, CAPTURE, DRAIN} state_t;

    state_t              state, state_d;
    logic                cpl_q, hs_q, vs_q;
    logic                pix_evt, hs_fall, vs_fall;
    logic [XW-1:0]       x, x_d, x_p;
    logic [YW-1:0]       y, y_d;
    logic [ADDR_W-1:0]   line_base, base_d;
    logic [7:0]          pack, pack_d, pack_p;
    logic                take;
    logic                push, push_ok, pop;
    logic [ADDR_W+7:0]   push_e;
    logic                short_set, drop_pix;
    logic [ADDR_W+7:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic [ADDR_W+7:0]   head;

    assign pix_evt = cpl & ~cpl_q & valid;
    assign hs_fall = hs_q & ~hs;
    assign vs_fall = vs_q & ~vs;

    // Input history for edge detection; syncs idle high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpl_q <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            cpl_q <= cpl;
            hs_q  <= hs;
            vs_q  <= vs;
        end
    end

    // Capture state, position counters and the byte being assembled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SYNC;
            x         <= '0;
            y         <= '0;
            line_base <= '0;
            pack      <= '0;
        end else begin
            state     <= state_d;
            x         <= x_d;
            y         <= y_d;
            line_base <= base_d;
            pack      <= pack_d;
        end
    end

    // Next state: a pixel in this cycle is folded in before any line or frame end.
    always_comb begin
        state_d   = state;
        x_d       = x;
        y_d       = y;
        base_d    = line_base;
        pack_d    = pack;
        push      = 1'b0;
        push_e    = '0;
        short_set = 1'b0;
        drop_pix  = 1'b0;
        take      = (state == CAPTURE) && pix_evt && (x < X_MAX) && (y < Y_MAX);
        x_p       = x + XW'(take);
        pack_p    = take ? (((x[1:0] == 2'd0) ? 8'h00 : pack) | ({pixel, 6'b0} >> {x[1:0], 1'b0})) : pack;
        case (state)
            SYNC: begin
                if (vs_fall) begin
                    state_d = CAPTURE;
                    x_d     = '0;
                    y_d     = '0;
                    base_d  = '0;
                    pack_d  = '0;
                end
            end
            CAPTURE: begin
                x_d    = x_p;
                pack_d = pack_p;
                if (take && x[1:0] == 2'd3) begin
                    push   = 1'b1;
                    push_e = {line_base + ADDR_W'(x >> 2), pack_p};
                end
                if ((hs_fall || vs_fall) && x_p != '0) begin
                    if (x_p[1:0] != 2'd0) begin
                        push   = 1'b1;
                        push_e = {line_base + ADDR_W'(x_p >> 2), pack_p};
                    end
                    if (hs_fall) begin
                        short_set = x_p < X_MAX;
                        x_d       = '0;
                        y_d       = y + YW'(1);
                        base_d    = line_base + STRIDE;
                    end
                end
                if (vs_fall) state_d = DRAIN;
            end
            DRAIN: begin
                drop_pix = pix_evt;
                if (count == '0) begin
                    state_d = CAPTURE;
                    x_d     = '0;
                    y_d     = '0;
                    base_d  = '0;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    assign pop        = fb_wr & fb_ready;
    assign push_ok    = push & ((count < C_MAX) | pop);
    assign fb_wr      = count != '0;
    assign head       = mem[rd_ptr];
    assign fb_a       = fb_wr ? head[ADDR_W+7:8] : '0;
    assign fb_d       = fb_wr ? head[7:0] : 8'h00;
    assign frame_done = (state == DRAIN) && (count == '0);

    // FIFO storage; contents are only observed through the gated head.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_e;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_ok);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(push_ok) - CW'(pop);
        end
    end

    // Sticky status; a new event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow   <= 1'b0;
            short_line <= 1'b0;
        end else begin
            overflow   <= drop_pix | (push & ~push_ok) | (overflow & ~clr_status);
            short_line <= short_set | (short_line & ~clr_status);
        end
    end
endmodule

// File: tb/tb_lcd_capture.sv
// tb_lcd_capture: directed stimulus with a queued scoreboard checked by an independent write monitor
module tb_lcd_capture;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst, hs, vs, cpl, valid, clr_status, fb_ready;
    logic [1:0]    pixel;
    logic [AW-1:0] fb_a;
    logic [7:0]    fb_d;
    logic          fb_wr, frame_done, overflow, short_line;

    logic [AW+7:0] q[$];
    int            checks = 0, errors = 0, n_wr = 0, fd_count = 0;
    logic [AW-1:0] last_a;
    time           last_pop_t, fd_t;

    lcd_capture dut (
        .clk(clk), .rst(rst), .hs(hs), .vs(vs), .cpl(cpl), .pixel(pixel), .valid(valid),
        .clr_status(clr_status), .fb_a(fb_a), .fb_d(fb_d), .fb_wr(fb_wr), .fb_ready(fb_ready),
        .frame_done(frame_done), .overflow(overflow), .short_line(short_line)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    // Monitor: every accepted write is compared against the head of the expected queue.
    always @(negedge clk) begin
        logic [AW+7:0] e;
        if (rst && fb_wr && fb_ready) begin
            n_wr++;
            last_a = fb_a;
            last_pop_t = $time;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected none", fb_a, fb_d);
            end else begin
                e = q.pop_front();
                chk("wr_addr", 32'(fb_a), 32'(e[AW+7:8]));
                chk("wr_data", 32'(fb_d), 32'(e[7:0]));
            end
        end
        if (rst && frame_done) begin
            fd_count++;
            fd_t = $time;
            chk("fd_with_pending", 32'(q.size()), 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [1:0] p);
        cpl = 1'b1; valid = 1'b1; pixel = p;
        step();
        cpl = 1'b0; valid = 1'b0;
        step();
    endtask

    task automatic hsync();
        hs = 1'b0; step();
        hs = 1'b1; step();
    endtask

    task automatic vsync();
        vs = 1'b0; step();
        vs = 1'b1; step();
    endtask

    task automatic expect_wr(input int a, input logic [7:0] d);
        q.push_back({AW'(a), d});
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (q.size() == 0 && !fb_wr) break;
            step();
        end
        chk(name, 32'(q.size()) + 32'(fb_wr), 0);
    endtask

    task automatic clear_flags();
        clr_status = 1'b1; step();
        clr_status = 1'b0; step();
    endtask

    initial begin
        rst = 1'b0; hs = 1'b1; vs = 1'b1; cpl = 1'b0; valid = 1'b0; pixel = 2'd0;
        clr_status = 1'b0; fb_ready = 1'b1;
        repeat (3) step();
        chk("rst_fb_wr", 32'(fb_wr), 0);
        chk("rst_fb_a", 32'(fb_a), 0);
        chk("rst_fb_d", 32'(fb_d), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_short_line", 32'(short_line), 0);
        rst = 1'b1;
        step();

        // Pixels before the first vsync are ignored; then 3,2,1,0 -> 0xE4 at 0.
        pix(2'd3); pix(2'd2); pix(2'd1); pix(2'd0);
        chk("sync_ignored", 32'(fb_wr), 0);
        vsync();
        expect_wr(0, 8'hE4);
        pix(2'd3); pix(2'd2); pix(2'd1); pix(2'd0);
        wait_drain("t1_drain");
        vsync();

        // Full frame with pixel = x%4.
        fd_count = 0;
        n_wr = 0;
        for (int yy = 0; yy < 144; yy++) begin
            for (int xx = 0; xx < 160; xx++) begin
                if (xx % 4 == 3) expect_wr(yy * 40 + xx / 4, 8'h1B);
                pix(2'(xx % 4));
            end
            hsync();
        end
        vsync();
        wait_drain("frame_drain");
        repeat (3) step();
        chk("frame_writes", 32'(n_wr), 5760);
        chk("frame_last_addr", 32'(last_a), 32'h167F);
        chk("frame_done_count", 32'(fd_count), 1);
        chk("frame_overflow", 32'(overflow), 0);
        chk("frame_short", 32'(short_line), 0);

        // Stalled sink: 40 bytes pushed, only the first 8 survive.
        fb_ready = 1'b0;
        for (int g = 0; g < 40; g++) begin
            if (g < 8) expect_wr(g, 8'(8'h55 * (g % 4)));
            repeat (4) pix(2'(g % 4));
        end
        hsync();
        chk("stall_overflow", 32'(overflow), 1);
        chk("stall_short", 32'(short_line), 0);
        fb_ready = 1'b1;
        wait_drain("stall_drain");
        clear_flags();
        chk("clr_overflow", 32'(overflow), 0);

        // Short line of 6 pixels at base 40, then next line at base 80.
        expect_wr(40, 8'hFF);
        expect_wr(41, 8'hF0);
        repeat (6) pix(2'd3);
        hsync();
        chk("short_set", 32'(short_line), 1);
        expect_wr(80, 8'h55);
        repeat (4) pix(2'd1);
        wait_drain("short_drain");
        clear_flags();
        chk("clr_short", 32'(short_line), 0);

        // Drain with a slow sink; pixels during drain are dropped.
        fb_ready = 1'b0;
        for (int g = 1; g <= 4; g++) begin
            expect_wr(80 + g, 8'hAA);
            repeat (4) pix(2'd2);
        end
        fd_count = 0;
        vsync();
        pix(2'd1);
        chk("drain_overflow", 32'(overflow), 1);
        chk("drain_no_done", 32'(fd_count), 0);
        chk("drain_pending", 32'(fb_wr), 1);
        for (int i = 0; i < 300; i++) begin
            fb_ready = (i % 3 == 0);
            step();
            if (q.size() == 0 && !fb_wr) break;
        end
        chk("slow_drain", 32'(q.size()) + 32'(fb_wr), 0);
        fb_ready = 1'b1;
        repeat (3) step();
        chk("slow_done_count", 32'(fd_count), 1);
        chk("done_after_pop", 32'(fd_t - last_pop_t), 10);
        clear_flags();

        // Reset mid-line with entries pending.
        fb_ready = 1'b0;
        repeat (8) pix(2'd3);
        chk("pre_rst_pending", 32'(fb_wr), 1);
        rst = 1'b0;
        #1;
        chk("rst_clears_fifo", 32'(fb_wr), 0);
        step();
        rst = 1'b1;
        fb_ready = 1'b1;
        step();
        repeat (4) pix(2'd2);
        chk("post_rst_sync", 32'(fb_wr), 0);
        vsync();
        expect_wr(0, 8'h1B);
        pix(2'd0); pix(2'd1); pix(2'd2); pix(2'd3);
        wait_drain("post_rst_drain");
        chk("post_rst_overflow", 32'(overflow), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
